seq_detect_sched: RTL
=====================

// Module: seq_detect_sched
// PURPOSE
//  Time-shares one "two consecutive ones" Mealy detector (z = w & Y; Y: A=0 -> B=1 on w=1, B -> A on w=0)
//  among N_CH serial bit-stream requesters. Round-robin arbiter grants one bit per cycle; per-channel
//  detector state lives in a state register file. Result (channel, z) is presented on a valid/ready output port.
// PARAMETERS
//  N_CH   4                 number of requester channels (2..16)
//  CH_W   $clog2(N_CH)      width of channel index
// PORTS
//  clk        in   1          clock, all logic on posedge
//  rst        in   1          reset, synchronous, active-high
//  req_valid  in   N_CH       channel i has a bit to deliver
//  req_bit    in   N_CH       serial bit w for channel i
//  req_ready  out  N_CH       one-hot grant; bit i accepted when req_valid[i] & req_ready[i]
//  ch_clr     in   N_CH       force channel i detector state to A
//  det_valid  out  1          result slot holds a valid result
//  det_ready  in   1          downstream accepts result
//  det_ch     out  CH_W       channel the result belongs to
//  det_z      out  1          detector output z for that bit
//  busy       out  1          det_valid & ~det_ready (output stalled)
// BEHAVIOUR
//  - Reset: state[i]=A for all i, rr_ptr=N_CH-1, det_valid=0, det_ch=0, det_z=0, req_ready=0.
//  - Output slot free when ~det_valid | det_ready. req_ready is combinational: 0 when slot not free,
//    else one-hot to first i with req_valid[i] searching rr_ptr+1, rr_ptr+2, ... modulo N_CH (wraps).
//  - On accept of channel g: det_valid<=1, det_ch<=g, det_z<=req_bit[g] & state[g],
//    state[g]<=req_bit[g] (A on 0, B on 1), rr_ptr<=g. Latency: bit accepted cycle t -> result at t+1.
//  - No accept and det_ready=1: det_valid<=0. det_valid=1 & det_ready=0: det_ch/det_z/det_valid held, no grant.
//  - Full throughput: accept and drain in the same cycle allowed (one result per clk).
//  - Controller FSM: EMPTY (det_valid=0) -> FULL on accept; FULL -> FULL on accept&det_ready or ~det_ready;
//    FULL -> EMPTY on det_ready & no accept.
//  - Channel state only changes on its own accept or ch_clr; other channels' states untouched.
//  - ch_clr[i] same cycle as accept of i: det_z uses pre-clear state; clr wins, state[i]<=A.
//  - Only one channel requesting: granted every free cycle regardless of rr_ptr.
//  - rst asserted mid-stream: all state/outputs return to reset values next edge; in-flight result dropped.
//  - req_valid deassert while stalled is legal; no bit is lost because req_ready was 0.
// CONFIGURATION
//  SDS_HITCNT_EN defined: adds output hit_cnt [N_CH*8], per-channel 8-bit counter of accepted bits with
//    det_z=1, saturating at 255, cleared by rst or ch_clr[i] (clr wins over same-cycle increment);
//    field i at hit_cnt[8*i+7:8*i].
//  SDS_HITCNT_EN undefined: no hit_cnt port, no counter logic; all other behaviour identical.
// TESTING
//  1 rst=1 one clk, det_ready=1 -> det_valid=0, req_ready=0, all states A, rr_ptr=N_CH-1.
//  2 ch0 only, bits 0,1,1,1,0,1 on consecutive cycles -> det_z=0,0,1,1,0,0, det_ch=0, one cycle later each.
//  3 all 4 channels valid continuously, det_ready=1 -> grants ch0,1,2,3,0,... one per clk, no gaps.
//  4 ch2 state B, det_ready=0 for 3 clk -> det_valid/det_ch/det_z stable, req_ready=0, busy=1; release -> next grant.
//  5 ch1 state B, accept bit 1 with ch_clr[1]=1 -> det_z=1, then next bit 1 on ch1 -> det_z=0.
//  6 SDS_HITCNT_EN: 300 consecutive 1s on ch3 -> hit_cnt[31:24]=255; ch_clr[3] -> 0.

Source files
------------

// File: rtl/seq_detect_sched_if.sv
// Request/result bundle for seq_detect_sched. The DUT side uses the slave modport and the driver side uses the master modport.
// When SDS_HITCNT_EN is defined, the bundle also carries the per-channel hit counters.
interface seq_detect_sched_if #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
);
    logic [N_CH-1:0] req_valid;
    logic [N_CH-1:0] req_bit;
    logic [N_CH-1:0] req_ready;
    logic [N_CH-1:0] ch_clr;
    logic            det_valid;
    logic            det_ready;
    logic [CH_W-1:0] det_ch;
    logic            det_z;
    logic            busy;
`ifdef SDS_HITCNT_EN
    logic [N_CH*8-1:0] hit_cnt;

    modport master (
        output req_valid, req_bit, ch_clr, det_ready,
        input  req_ready, det_valid, det_ch, det_z, busy, hit_cnt
    );
    modport slave (
        input  req_valid, req_bit, ch_clr, det_ready,
        output req_ready, det_valid, det_ch, det_z, busy, hit_cnt
    );
`else
    modport master (
        output req_valid, req_bit, ch_clr, det_ready,
        input  req_ready, det_valid, det_ch, det_z, busy
    );
    modport slave (
        input  req_valid, req_bit, ch_clr, det_ready,
        output req_ready, det_valid, det_ch, det_z, busy
    );
`endif
endinterface

// File: rtl/seq_detect_sched.sv
// A single two-consecutive-ones Mealy detector, time-shared round-robin among N_CH serial channels.
// Define SDS_HITCNT_EN to add saturating per-channel hit counters on bus.hit_cnt.
module seq_detect_sched #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    seq_detect_sched_if.slave bus
);
    typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} ctrl_state_e;

    ctrl_state_e     ctrl_q, ctrl_d;
    logic [N_CH-1:0] state_q, state_d;
    logic [CH_W-1:0] rr_ptr_q;
    logic [CH_W-1:0] det_ch_q;
    logic            det_z_q;

    logic [N_CH-1:0] grant;
    logic [N_CH-1:0] accept_vec;
    logic [CH_W-1:0] grant_idx;
    logic [CH_W-1:0] idx;
    logic            found;
    logic            slot_free;
    logic            accept;

    assign slot_free = (ctrl_q == S_EMPTY) | bus.det_ready;

    // Search starts just past the last winner, so the previous winner has the lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = CH_W'((int'(rr_ptr_q) + k) % N_CH);
            if (!found && bus.req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

    assign accept         = slot_free & found & ~rst;
    assign accept_vec     = accept ? grant : '0;
    assign bus.req_ready  = accept_vec;
    assign bus.det_valid  = (ctrl_q == S_FULL);
    assign bus.det_ch     = det_ch_q;
    assign bus.det_z      = det_z_q;
    assign bus.busy       = (ctrl_q == S_FULL) & ~bus.det_ready;

    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            S_EMPTY: if (accept) ctrl_d = S_FULL;
            S_FULL:  if (bus.det_ready && !accept) ctrl_d = S_EMPTY;
            default: ctrl_d = S_EMPTY;
        endcase
    end

    // When a clear and an accept hit the same channel, the clear wins for the stored state.
    // The emitted z still uses the state from before the clear.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        assign state_d[gi] = bus.ch_clr[gi] ? 1'b0
                           : (accept_vec[gi] ? bus.req_bit[gi] : state_q[gi]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= S_EMPTY;
            state_q  <= '0;
            rr_ptr_q <= CH_W'(N_CH - 1);
            det_ch_q <= '0;
            det_z_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            state_q <= state_d;
            if (accept) begin
                rr_ptr_q <= grant_idx;
                det_ch_q <= grant_idx;
                det_z_q  <= |(accept_vec & bus.req_bit & state_q);
            end
        end
    end

`ifdef SDS_HITCNT_EN
    logic [N_CH*8-1:0] hit_q, hit_d;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_hit
        logic hit_inc;
        assign hit_inc = accept_vec[gi] & bus.req_bit[gi] & state_q[gi];
        assign hit_d[8*gi +: 8] = bus.ch_clr[gi] ? 8'd0
                                : ((hit_inc && hit_q[8*gi +: 8] != 8'hFF) ? hit_q[8*gi +: 8] + 8'd1
                                                                         : hit_q[8*gi +: 8]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign bus.hit_cnt = hit_q;
`endif
endmodule
